// File: rtl/safe_reset_sequencer.sv
// safe_reset_sequencer: debounces clock-error flags and software requests into a staged
// main/peripheral reset, with ack timeout and retry-limited permanent lockout.
module safe_reset_sequencer #(
    parameter int DEBOUNCE    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int RELEASE_GAP = 8,
    parameter int ACK_TIMEOUT = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk_safety_i,
    input  logic       rst_safety_i,
    input  logic       clk_main_error_i,
    input  logic       clk_safety_error_i,
    input  logic       sw_reset_req_i,
    input  logic       fault_clear_i,
    input  logic       main_rst_ack_i,
    output logic       rst_periph_req_o,
    output logic       rst_main_req_o,
    output logic       seq_busy_o,
    output logic       lockout_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] cause_o
);
    localparam int TMAX = (ACK_TIMEOUT > HOLD_CYCLES) ?
                          ((ACK_TIMEOUT > RELEASE_GAP) ? ACK_TIMEOUT : RELEASE_GAP) :
                          ((HOLD_CYCLES > RELEASE_GAP) ? HOLD_CYCLES : RELEASE_GAP);
    localparam int TW = $clog2(TMAX) + 1;
    localparam int DW = $clog2(DEBOUNCE) + 1;

    typedef enum logic [2:0] {S_IDLE, S_DEB, S_WAIT, S_HOLD, S_RELEASE, S_LOCK} state_t;

    state_t        state, state_n;
    logic [DW-1:0] deb_cnt, deb_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [1:0]    retry_n;
    logic [2:0]    cause_n;
    logic          err, trig;

    assign err = clk_main_error_i | clk_safety_error_i;

    always_comb begin
        state_n = state;
        deb_n   = deb_cnt;
        tmr_n   = tmr;
        retry_n = retry_cnt_o;
        cause_n = cause_o;
        trig    = 1'b0;
        case (state)
            S_IDLE: begin
                if (fault_clear_i) retry_n = '0;
                if (sw_reset_req_i || (err && DEBOUNCE == 1)) trig = 1'b1;
                else if (err) begin
                    state_n = S_DEB;
                    deb_n   = DW'(1);
                end
            end
            S_DEB: begin
                if (sw_reset_req_i || (err && deb_cnt == DW'(DEBOUNCE - 1))) trig = 1'b1;
                else if (err) deb_n = deb_cnt + 1'b1;
                else begin
                    state_n = S_IDLE;
                    deb_n   = '0;
                end
            end
            S_WAIT: begin
                if (main_rst_ack_i) begin
                    state_n = S_HOLD;
                    tmr_n   = '0;
                end else if (tmr == TW'(ACK_TIMEOUT)) state_n = S_LOCK;
                else tmr_n = tmr + 1'b1;
            end
            S_HOLD: begin
                if (tmr == TW'(HOLD_CYCLES - 1)) begin
                    state_n = S_RELEASE;
                    tmr_n   = '0;
                end else tmr_n = tmr + 1'b1;
            end
            S_RELEASE: begin
                if (tmr == TW'(RELEASE_GAP - 1)) begin
                    state_n = S_IDLE;
                    tmr_n   = '0;
                    retry_n = (retry_cnt_o == 2'd3) ? 2'd3 : retry_cnt_o + 2'd1;
                end else tmr_n = tmr + 1'b1;
            end
            default: ;
        endcase
        // a trigger checks the retry budget after any same-cycle clear has been applied
        if (trig) begin
            cause_n = {sw_reset_req_i, clk_safety_error_i, clk_main_error_i};
            state_n = (retry_n == 2'(MAX_RETRY)) ? S_LOCK : S_WAIT;
            tmr_n   = '0;
            deb_n   = '0;
        end
    end

    always_ff @(posedge clk_safety_i) begin
        if (rst_safety_i) begin
            state            <= S_IDLE;
            deb_cnt          <= '0;
            tmr              <= '0;
            rst_periph_req_o <= 1'b0;
            rst_main_req_o   <= 1'b0;
            seq_busy_o       <= 1'b0;
            lockout_o        <= 1'b0;
            retry_cnt_o      <= '0;
            cause_o          <= '0;
        end else begin
            state            <= state_n;
            deb_cnt          <= deb_n;
            tmr              <= tmr_n;
            rst_periph_req_o <= state_n inside {S_WAIT, S_HOLD, S_RELEASE, S_LOCK};
            rst_main_req_o   <= state_n inside {S_WAIT, S_HOLD, S_LOCK};
            seq_busy_o       <= state_n != S_IDLE;
            lockout_o        <= state_n == S_LOCK;
            retry_cnt_o      <= retry_n;
            cause_o          <= cause_n;
        end
    end
endmodule

// File: doc/safe_reset_sequencer.md
# safe_reset_sequencer

Safety-island reset sequencer that acts on the clock-error flags raised by the safety clock/reset monitor and on software reset requests. It debounces faults, then issues a staged reset to the peripheral and main domains. It waits for the main domain to acknowledge the reset, holds it, and releases the domains in reverse order. Repeated faults escalate to a permanent lockout. It runs entirely in the safety clock domain.

## Interface
- DEBOUNCE, 4: consecutive high samples required on a clock-error input (≥1)
- HOLD_CYCLES, 16: cycles the reset is held after ack (≥1)
- RELEASE_GAP, 8: cycles between main release and peripheral release (≥1)
- ACK_TIMEOUT, 64: max cycles waiting for main_rst_ack_i (≥1)
- MAX_RETRY, 3: completed sequences allowed before lockout (1..3)

Ports:
- clk_safety_i  in  1  safety clock; sole clock of the block
- rst_safety_i  in  1  reset; synchronous, active-high
- clk_main_error_i  in  1  main-clock frequency error, already synchronized to clk_safety_i
- clk_safety_error_i  in  1  safety-clock frequency error
- sw_reset_req_i  in  1  single-cycle software reset request; not debounced
- fault_clear_i  in  1  clears retry_cnt_o; honoured only in IDLE
- main_rst_ack_i  in  1  main domain confirms it is in reset
- rst_periph_req_o  out  1  peripheral-domain reset request, active-high
- rst_main_req_o  out  1  main-domain reset request, active-high
- seq_busy_o  out  1  high in every state except IDLE
- lockout_o  out  1  permanent-fault indication
- retry_cnt_o  out  2  completed sequences since reset or last clear
- cause_o  out  3  cause latched at assertion: [0] main clk, [1] safety clk, [2] software

## Operation
- All outputs are registered. Reset values: every output is 0, the state is IDLE, and all counters are 0.
- States: IDLE, DEBOUNCE, WAIT_ACK, HOLD, RELEASE, LOCKOUT.
- IDLE
  - If (clk_main_error_i | clk_safety_error_i): go to DEBOUNCE with deb_cnt=1.
  - If sw_reset_req_i: trigger immediately.
  - The software request has priority. Faults present in the same cycle are OR'd into the cause.
- DEBOUNCE
  - If either error input is still high: deb_cnt++.
  - If both error inputs drop: return to IDLE, deb_cnt=0, and no output changes.
  - At deb_cnt==DEBOUNCE with an error still high: trigger.
  - sw_reset_req_i during DEBOUNCE triggers at once.
- Trigger
  - If retry_cnt_o==MAX_RETRY: go to LOCKOUT.
  - Otherwise:
    - latch cause_o from the inputs sampled that cycle;
    - set rst_periph_req_o=1 and rst_main_req_o=1;
    - go to WAIT_ACK with timer=0.
- WAIT_ACK
  - On main_rst_ack_i: go to HOLD with timer=0.
  - If timer reaches ACK_TIMEOUT with no ack: go to LOCKOUT.
- HOLD: after HOLD_CYCLES cycles, set rst_main_req_o=0 and go to RELEASE with timer=0.
- RELEASE
  - After RELEASE_GAP cycles: set rst_periph_req_o=0, increment retry_cnt_o (saturating at 3), and go to IDLE.
- LOCKOUT
  - Both reset requests are 1 and lockout_o=1.
  - Terminal state; only rst_safety_i exits it.
  - All inputs, including fault_clear_i, are ignored.
- Inputs ignored outside IDLE/DEBOUNCE: error inputs, sw_reset_req_i and main_rst_ack_i are not queued and not latched.
- Stale ack: main_rst_ack_i asserted in IDLE/DEBOUNCE is ignored.
- fault_clear_i
  - In IDLE: clears retry_cnt_o to 0.
  - Same cycle as a new fault: the clear is applied and the fault still enters DEBOUNCE.
- cause_o holds its value until the next trigger. Lockout entered via retry exhaustion also latches the cause.

## Timing
- sw_reset_req_i high at cycle N in IDLE: reset requests and seq_busy_o are high at N+1.
- Error input high for cycles N..N+DEBOUNCE-1: reset requests are high at N+DEBOUNCE.
- Ack sampled at cycle A:
  - rst_main_req_o falls at A+1+HOLD_CYCLES;
  - rst_periph_req_o falls RELEASE_GAP cycles after that.
  - retry_cnt_o increments and seq_busy_o falls in the same cycle as rst_periph_req_o falls.
- Timeout: with no ack, lockout_o rises ACK_TIMEOUT+1 cycles after the requests rise.
- rst_safety_i mid-sequence: on the next edge all outputs are 0 and the state is IDLE. No release ordering is enforced.
- Counter widths: counters are sized $clog2(max parameter)+1 and never wrap. Timer comparisons use ==.

## Test plan
- **Software request:** sw_reset_req_i pulse at cycle 10, ack at cycle 13 → requests high 11; main low 30; periph low 38; retry_cnt_o=1; cause_o=3'b100.
- **Debounce filter:** clk_main_error_i high for 3 cycles then low → no reset request, seq_busy_o falls. Held 4 cycles → requests high the cycle after the 4th sample, cause_o=3'b001.
- **Ack timeout:** clk_safety_error_i held, main_rst_ack_i never asserted → lockout_o=1 exactly 65 cycles after requests rise; requests stay 1; fault_clear_i has no effect.
- **Retry exhaustion:** three complete sw sequences → retry_cnt_o=3; 4th request → LOCKOUT, requests high. Repeat with fault_clear_i pulsed in IDLE before the 4th → normal sequence, retry_cnt_o=1.
- **Simultaneous events:** sw_reset_req_i during DEBOUNCE of clk_main_error_i → immediate trigger, cause_o=3'b101. A second sw request in HOLD is ignored.
- **Reset mid-sequence:** rst_safety_i asserted in HOLD → next edge all outputs 0. Stale main_rst_ack_i in IDLE → no response.
